// File: rtl/par_pred_pkg.sv
// Shared helpers for the parity-predicted adder pipeline.
package par_pred_pkg;

  // Widest vector the parity helper accepts; narrower vectors are
  // zero-extended, which leaves their XOR reduction unchanged.
  localparam int PARITY_MAX_W = 64;

  // Widest error counter supported. Each instance slices its own
  // saturation value from the low bits of ERR_CNT_MAX.
  localparam int ERR_CNT_W_MAX = 32;
  localparam logic [ERR_CNT_W_MAX-1:0] ERR_CNT_MAX = '1;

  // Even parity: XOR reduction of the vector.
  function automatic logic parity(input logic [PARITY_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/ppa_ripple_core.sv
// Combinational ripple-carry adder with parity prediction from the carry chain.
module ppa_ripple_core #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             a_par,
  input  logic             b_par,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic [WIDTH-1:0] c,
  output logic             s_par
);

  logic [WIDTH:0] cy;

  // Ripple the carry through every bit position and form the sum bits.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can leave it unassigned and infer a latch.
    cy    = '0;
    s     = '0;
    cy[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      s[i]    = a[i] ^ b[i] ^ cy[i];
      cy[i+1] = (a[i] & b[i]) | (a[i] & cy[i]) | (b[i] & cy[i]);
    end
  end

  assign c    = cy[WIDTH-1:0];
  assign cout = cy[WIDTH];

  // Since s = a ^ b ^ c bitwise, parity(s) = parity(a) ^ parity(b) ^ parity(c).
  // Using the operand parity bits, not the operands, means a corrupt operand
  // parity bit shows up as a sum-parity error downstream.
  assign s_par = a_par ^ b_par ^ (^c);

endmodule

// File: rtl/par_pred_adder_pipe.sv
// Two-stage stall-all pipeline around the parity-predicted ripple adder,
// with operand/sum parity checks, sticky error flag and saturating counter.
module par_pred_adder_pipe
  import par_pred_pkg::*;
#(
  parameter int WIDTH     = 8,  // 2..PARITY_MAX_W
  parameter int ERR_CNT_W = 8   // 1..ERR_CNT_W_MAX
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 a_par,
  input  logic                 b_par,
  input  logic                 cin,
  input  logic                 inject,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     s,
  output logic                 cout,
  output logic                 s_par,
  output logic                 sum_err,
  output logic                 op_err,
  output logic                 err_sticky,
  output logic [ERR_CNT_W-1:0] err_cnt,
  input  logic                 err_clr
);

  localparam logic [ERR_CNT_W-1:0] CNT_MAX = ERR_CNT_MAX[ERR_CNT_W-1:0];

  // Stage 1 registers
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_a_par;
  logic             s1_b_par;
  logic             s1_cin;
  logic             s1_inject;

  // Stage 2 combinational results
  logic [WIDTH-1:0] core_s;
  logic             core_cout;
  logic             core_s_par;
  logic [WIDTH-1:0] carry_vec_unused;  // exported by the core for debug visibility only
  logic [WIDTH-1:0] s_del;
  logic             sum_err_d;
  logic             op_err_d;

  logic en;
  logic err_hit;

  // Whole pipeline advances together whenever the output slot is free.
  assign en       = !out_valid || out_ready;
  assign in_ready = en && !rst;

  // Stage 1: capture the operand beat (bubbles travel as s1_valid = 0).
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: the datapath registers are reset too, so bubbles never carry X into the outputs.
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_a_par  <= 1'b0;
      s1_b_par  <= 1'b0;
      s1_cin    <= 1'b0;
      s1_inject <= 1'b0;
    end else if (en) begin
      s1_valid  <= in_valid;
      s1_a      <= a;
      s1_b      <= b;
      s1_a_par  <= a_par;
      s1_b_par  <= b_par;
      s1_cin    <= cin;
      s1_inject <= inject;
    end
  end

  ppa_ripple_core #(.WIDTH(WIDTH)) u_core (
    .a     (s1_a),
    .b     (s1_b),
    .cin   (s1_cin),
    .a_par (s1_a_par),
    .b_par (s1_b_par),
    .s     (core_s),
    .cout  (core_cout),
    .c     (carry_vec_unused),
    .s_par (core_s_par)
  );

  // Fault injection flips s[0] after prediction, so the checker must catch it.
  assign s_del     = core_s ^ WIDTH'(s1_inject);
  assign sum_err_d = core_s_par ^ parity(PARITY_MAX_W'(s_del));
  assign op_err_d  = (s1_a_par != parity(PARITY_MAX_W'(s1_a)))
                  || (s1_b_par != parity(PARITY_MAX_W'(s1_b)));

  // Stage 2: register the result and its checks; hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      s         <= '0;
      cout      <= 1'b0;
      s_par     <= 1'b0;
      sum_err   <= 1'b0;
      op_err    <= 1'b0;
    end else if (en) begin
      out_valid <= s1_valid;
      s         <= s_del;
      cout      <= core_cout;
      s_par     <= core_s_par;
      sum_err   <= sum_err_d;
      op_err    <= op_err_d;
    end
  end

  // An erroneous beat counts only once, when it is actually delivered.
  assign err_hit = out_valid && out_ready && (sum_err || op_err);

  // Error bookkeeping: a clear coinciding with a hit leaves that hit recorded.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_sticky <= 1'b0;
      err_cnt    <= '0;
    end else if (err_clr) begin
      err_sticky <= err_hit;
      err_cnt    <= err_hit ? ERR_CNT_W'(1) : '0;
    end else if (err_hit) begin
      err_sticky <= 1'b1;
      if (err_cnt != CNT_MAX) begin
        err_cnt <= err_cnt + ERR_CNT_W'(1);
      end
    end
  end

endmodule
